// File: rtl/booth8_pp_gen_pkg.sv
// Shared definitions for the radix-8 Booth partial-product generator:
// FSM states, digit-select encoding and the window decoder.
package booth8_pp_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_M1   = 3'd1,
        SEL_M2   = 3'd2,
        SEL_M3   = 3'd3,
        SEL_M4   = 3'd4
    } sel_e;

    typedef struct packed {
        sel_e sel;
        logic neg;
    } digit_t;

    // Digit count: ceil(k/3) windows of three multiplier bits each.
    function automatic int iter_of(input int k);
        return (k + 2) / 3;
    endfunction

    // Window {y[3i+2], y[3i+1], y[3i], y[3i-1]} -> magnitude select and sign.
    function automatic digit_t decode_window(input logic [3:0] w);
        digit_t r;
        r.sel = SEL_ZERO;
        r.neg = w[3] && (w != 4'b1111);
        unique case (w)
            4'b0000, 4'b1111:                   r.sel = SEL_ZERO;
            4'b0001, 4'b0010, 4'b1101, 4'b1110: r.sel = SEL_M1;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: r.sel = SEL_M2;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: r.sel = SEL_M3;
            4'b0111, 4'b1000:                   r.sel = SEL_M4;
            default:                            r.sel = SEL_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth8_pp_gen_if.sv
// Request/partial-product bus between the Booth sequencer and its user/adder_net.
interface booth8_pp_gen_if #(
    parameter int k = 4
);
    logic                go;
    logic signed [k-1:0] multiplicand;
    logic signed [k-1:0] multiplier;
    logic                busy;
    logic                start;
    logic signed [k+2:0] srcA;
    logic                done;

    modport master (
        output go, multiplicand, multiplier,
        input  busy, start, srcA, done
    );

    modport slave (
        input  go, multiplicand, multiplier,
        output busy, start, srcA, done
    );
endinterface

// File: rtl/booth8_digit_sel.sv
// Combinational radix-8 digit selector: maps one 4-bit Booth window to d*M,
// sign-extended to k+3 bits. Stateless so an array variant can replicate it.
module booth8_digit_sel
    import booth8_pp_gen_pkg::*;
#(
    parameter int k = 4
) (
    input  logic        [3:0] w,
    input  logic signed [k-1:0] m,
    input  logic signed [k+2:0] m3,
    output logic signed [k+2:0] pp
);
    digit_t              dig;
    logic signed [k+2:0] m_x;
    logic signed [k+2:0] mag;

    always_comb begin
        dig = decode_window(w);
        m_x = {{3{m[k-1]}}, m};
        unique case (dig.sel)
            SEL_M1:  mag = m_x;
            SEL_M2:  mag = m_x <<< 1;
            SEL_M3:  mag = m3;
            SEL_M4:  mag = m_x <<< 2;
            default: mag = '0;
        endcase
        // +32 for M=-8 still fits: k+3 bits keeps one guard bit above 4M.
        pp = dig.neg ? -mag : mag;
    end
endmodule

// File: rtl/booth8_pp_gen.sv
// Radix-8 Booth recoder/sequencer: latches operands, precomputes 3M and streams
// one signed partial product per cycle to adder_net, framed by start/done.
module booth8_pp_gen
    import booth8_pp_gen_pkg::*;
#(
    parameter int k = 4
) (
    input logic            clk,
    input logic            rst,
    booth8_pp_gen_if.slave bus
);
    localparam int ITER = iter_of(k);
    localparam int YS   = 3 * ITER;
    localparam int YW   = YS + 1;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    state_e              state_q, state_d;
    logic signed [k-1:0] m_q, m_d;
    logic signed [k+2:0] m3_q, m3_d;
    logic [YW-1:0]       y_q, y_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                start_q, start_d;
    logic                done_q, done_d;

    logic signed [k+2:0] m_x;
    logic signed [k+2:0] pp;

    booth8_digit_sel #(.k(k)) u_digit_sel (
        .w  (y_q[3:0]),
        .m  (m_q),
        .m3 (m3_q),
        .pp (pp)
    );

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d = state_q;
        m_d     = m_q;
        m3_d    = m3_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        m_x     = {{3{m_q[k-1]}}, m_q};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    m_d     = bus.multiplicand;
                    y_d     = {YS'(bus.multiplier), 1'b0};
                    state_d = ST_PREP;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                end
            end
            ST_PREP: begin
                m3_d    = m_x + (m_x <<< 1);
                cnt_d   = '0;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                y_d   = {{3{y_q[YW-1]}}, y_q[YW-1:3]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous,
    // and the small operand registers are cleared too so an aborted op leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            m3_q    <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            m3_q    <= m3_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    // srcA depends on registered state only; zero outside the accumulate window.
    assign bus.srcA  = (state_q == ST_ACC) ? pp : '0;
    assign bus.busy  = busy_q;
    assign bus.start = start_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_booth8_pp_gen.sv
// Self-checking bench for booth8_pp_gen: models adder_net accumulation and checks
// products, partial products, latency, framing and abort behaviour.
module tb_booth8_pp_gen;
    localparam int K    = 4;
    localparam int ITER = (K + 2) / 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth8_pp_gen_if #(.k(K)) bus ();
    booth8_pp_gen #(.k(K)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // adder_net model: start clears, the next ITER beats accumulate srcA * 8^i.
    longint acc       = 0;
    int     k_idx     = ITER;
    int     start_cnt = 0;
    int     viol_cnt  = 0;
    longint done_res[$];
    int     done_edge[$];
    int     pp_log[$];

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            if (bus.start === 1'b1 && bus.done === 1'b1) viol_cnt++;
            if (bus.start === 1'b1) begin
                acc   = 0;
                k_idx = 0;
                start_cnt++;
                pp_log.delete();
                if (bus.srcA !== '0) viol_cnt++;
            end else if (k_idx < ITER) begin
                pp_log.push_back(int'(bus.srcA));
                acc += longint'(bus.srcA) * (longint'(1) << (3 * k_idx));
                k_idx++;
            end else if (bus.srcA !== '0) begin
                viol_cnt++;
            end
            if (bus.done === 1'b1) begin
                done_res.push_back(acc);
                done_edge.push_back(edge_cnt);
            end
        end
    end

    function automatic int bit_at(input int v, input int j);
        return (j < 0) ? 0 : ((v >>> j) & 1);
    endfunction

    // Expected i-th partial product from the Booth digit rule on sign-extended Y.
    function automatic int ref_pp(input int m, input int y, input int i);
        int d;
        d = -4 * bit_at(y, 3*i + 2) + 2 * bit_at(y, 3*i + 1) + bit_at(y, 3*i) + bit_at(y, 3*i - 1);
        return d * m;
    endfunction

    task automatic launch(input int m, input int y, output int e0);
        @(negedge clk);
        bus.go           = 1'b1;
        bus.multiplicand = K'(m);
        bus.multiplier   = K'(y);
        e0 = edge_cnt + 1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic check_op(input int m, input int y, input int e0, input string tag);
        bit     got;
        longint res;
        int     de;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_res.size() > 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        vectors++;
        if (!got) begin
            $display("FAIL %s timeout: no done within 40 cycles (m=%0d y=%0d)", tag, m, y);
            miscompares++;
            return;
        end
        res = done_res.pop_front();
        de  = done_edge.pop_front();
        if (res !== longint'(m * y)) begin
            $display("FAIL %s product: got %0d expected %0d (m=%0d y=%0d)", tag, res, m * y, m, y);
            miscompares++;
        end
        vectors++;
        if (de != e0 + ITER + 1) begin
            $display("FAIL %s latency: done after edge %0d expected edge %0d", tag, de, e0 + ITER + 1);
            miscompares++;
        end
        for (int i = 0; i < ITER; i++) begin
            vectors++;
            if (pp_log.size() <= i) begin
                $display("FAIL %s pp%0d: missing, expected %0d", tag, i, ref_pp(m, y, i));
                miscompares++;
            end else if (pp_log[i] != ref_pp(m, y, i)) begin
                $display("FAIL %s pp%0d: got %0d expected %0d", tag, i, pp_log[i], ref_pp(m, y, i));
                miscompares++;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.done !== 1'b0 || bus.srcA !== '0) begin
            $display("FAIL %s idle: busy=%b start=%b done=%b srcA=%0d expected all 0",
                     tag, bus.busy, bus.start, bus.done, bus.srcA);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.go = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL reset busy: got %b expected 0", bus.busy); miscompares++;
        end
        vectors++;
        if (bus.start !== 1'b0) begin
            $display("FAIL reset start: got %b expected 0", bus.start); miscompares++;
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            $display("FAIL reset done: got %b expected 0", bus.done); miscompares++;
        end
        vectors++;
        if (bus.srcA !== '0) begin
            $display("FAIL reset srcA: got %0d expected 0", bus.srcA); miscompares++;
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int ms[4] = '{7, -8, -8, 5};
        int ys[4] = '{7, -8, 7, -3};
        int e0;
        for (int i = 0; i < 4; i++) begin
            launch(ms[i], ys[i], e0);
            check_op(ms[i], ys[i], e0, "directed");
            check_idle("directed");
        end
    endtask

    task automatic test_random();
        int m, y, e0;
        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(15)) - 8;
            y = int'($urandom_range(15)) - 8;
            launch(m, y, e0);
            check_op(m, y, e0, "random");
        end
        check_idle("random");
    endtask

    task automatic test_back_to_back();
        int ms[3] = '{7, 0, -1};
        int ys[3] = '{7, -5, -1};
        int e0;
        @(negedge clk);
        bus.go           = 1'b1;
        bus.multiplicand = K'(ms[0]);
        bus.multiplier   = K'(ys[0]);
        e0 = edge_cnt + 1;
        for (int j = 0; j < 3; j++) begin
            check_op(ms[j], ys[j], e0, "b2b");
            if (j < 2) begin
                bus.multiplicand = K'(ms[j+1]);
                bus.multiplier   = K'(ys[j+1]);
                e0 = edge_cnt + 2;
                @(negedge clk);
                #1;
                vectors++;
                if (bus.busy !== 1'b0) begin
                    $display("FAIL b2b gap busy: got %b expected 0", bus.busy); miscompares++;
                end
                @(negedge clk);
                #1;
                vectors++;
                if (bus.busy !== 1'b1) begin
                    $display("FAIL b2b restart busy: got %b expected 1", bus.busy); miscompares++;
                end
            end else begin
                bus.go = 1'b0;
            end
        end
        check_idle("b2b");
    endtask

    task automatic test_abort();
        int e0;
        launch(3, 3, e0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_idle("abort");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (done_res.size() != 0) begin
            $display("FAIL abort done: got %0d done pulses expected 0", done_res.size());
            miscompares++;
            done_res.delete();
            done_edge.delete();
        end
        launch(3, 3, e0);
        check_op(3, 3, e0, "abort_next");
        check_idle("abort_next");
    endtask

    task automatic test_ignore_inputs();
        int e0, s0, m, y;
        for (int n = 0; n < 4; n++) begin
            m  = int'($urandom_range(15)) - 8;
            y  = int'($urandom_range(15)) - 8;
            s0 = start_cnt;
            launch(m, y, e0);
            fork
                check_op(m, y, e0, "ignore");
                begin
                    for (int c = 0; c < ITER + 2; c++) begin
                        bus.go           = (c == ITER + 1) ? 1'b1 : 1'($urandom_range(1));
                        bus.multiplicand = K'($urandom);
                        bus.multiplier   = K'($urandom);
                        @(negedge clk);
                    end
                    bus.go = 1'b0;
                end
            join
            repeat (3) @(negedge clk);
            #1;
            vectors++;
            if (start_cnt - s0 != 1) begin
                $display("FAIL ignore start count: got %0d expected 1", start_cnt - s0);
                miscompares++;
            end
        end
    endtask

    task automatic test_invariants();
        vectors++;
        if (viol_cnt != 0) begin
            $display("FAIL invariants: got %0d start/done overlaps or srcA outside window expected 0", viol_cnt);
            miscompares++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        test_ignore_inputs();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
